reg_alu_seq: RTL and testbench

Microsequencer directly upstream of reg_alu. It stores a short program of 21-bit control words and replays them one per issue slot onto reg_alu's control and data inputs: sel, wr, op, rd_addr_a, rd_addr_b, wr_addr and d_in. It captures reg_alu's cout and signals completion to the host with a start/busy/done handshake. This replaces hand-driven test vectors with a loadable, self-timed program.

---
 rtl/reg_alu_pkg.sv | 25 ++
 rtl/reg_alu_seq_if.sv | 16 +
 rtl/seq_imem.sv | 24 ++
 rtl/reg_alu_seq.sv | 92 +++++++++
 tb/tb_reg_alu_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared types and constants for reg_alu and its microsequencer.
//   Sequencer states, program geometry, instruction field bit positions and ALU op codes.
package reg_alu_pkg;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 21;
    localparam int DW    = 8;
    localparam int SEL_B  = 20;
    localparam int WR_B   = 19;
    localparam int OP_HI  = 18;
    localparam int OP_LO  = 17;
    localparam int RDA_HI = 16;
    localparam int RDA_LO = 14;
    localparam int RDB_HI = 13;
    localparam int RDB_LO = 11;
    localparam int WA_HI  = 10;
    localparam int WA_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_e;
endpackage

// File: rtl/reg_alu_seq_if.sv
// reg_alu_seq_if: control/data bus between the microsequencer and reg_alu.
//   master (sequencer): drives sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in; receives cout_in.
//   slave  (reg_alu):   receives the control/data fields; drives cout_in.
interface reg_alu_seq_if;
    import reg_alu_pkg::*;
    logic          sel;
    logic          wr;
    logic [1:0]    op;
    logic [2:0]    rd_addr_a;
    logic [2:0]    rd_addr_b;
    logic [2:0]    wr_addr;
    logic [DW-1:0] d_in;
    logic          cout_in;
    modport master (output sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, input cout_in);
    modport slave  (input sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, output cout_in);
endinterface

// File: rtl/seq_imem.sv
// seq_imem: DEPTH x IW program memory, synchronous write, registered read.
//   clk; we/waddr/wdata write port; re/raddr read request; ir holds the last word read.
module seq_imem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 21
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] ir
);
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] ir_q, ir_d;
    always_comb ir_d = re ? mem[raddr] : ir_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        ir_q <= ir_d;
    end
    assign ir = ir_q;
endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: microsequencer replaying a loaded program of control words onto reg_alu.
//   clk, reset (sync, active low); load_en/load_addr/load_data program write (IDLE only);
//   start/prog_len begin a run; busy/done/pc status; carry_flag sticky ALU carry;
//   alu: master side of the reg_alu bus, fields driven only during ISSUE.
module reg_alu_seq
    import reg_alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [IW-1:0]   load_data,
    input  logic            start,
    input  logic [AW:0]     prog_len,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   pc,
    output logic            carry_flag,
    reg_alu_seq_if.master   alu
);
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] ir;
    logic          idle, issue;
    assign idle  = state_q == IDLE;
    assign issue = state_q == ISSUE;
    seq_imem #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_imem (
        .clk   (clk),
        .we    (load_en && idle),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (state_q == FETCH),
        .raddr (pc_q),
        .ir    (ir)
    );
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: if (start) begin
                if (prog_len != '0) begin
                    len_d   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
                    pc_d    = '0;
                    carry_d = 1'b0;
                    state_d = FETCH;
                end else begin
                    state_d = DONE;
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                // Only ALU-result writes update the sticky carry.
                if (ir[SEL_B] && ir[WR_B]) carry_d = alu.cout_in;
                if ({1'b0, pc_q} == len_q - 1'b1) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            carry_q <= carry_d;
        end
    end
    assign busy          = (state_q == FETCH) || issue;
    assign done          = state_q == DONE;
    assign pc            = pc_q;
    assign carry_flag    = carry_q;
    assign alu.sel       = issue & ir[SEL_B];
    assign alu.wr        = issue & ir[WR_B];
    assign alu.op        = issue ? ir[OP_HI:OP_LO]   : '0;
    assign alu.rd_addr_a = issue ? ir[RDA_HI:RDA_LO] : '0;
    assign alu.rd_addr_b = issue ? ir[RDB_HI:RDB_LO] : '0;
    assign alu.wr_addr   = issue ? ir[WA_HI:WA_LO]   : '0;
    assign alu.d_in      = issue ? ir[IMM_HI:IMM_LO] : '0;
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: scoreboard bench for reg_alu_seq with a cycle-level program-replay model.
module tb_reg_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [20:0] load_data;
    logic        start;
    logic [4:0]  prog_len;
    logic        busy, done, carry_flag;
    logic [3:0]  pc;
    reg_alu_seq_if alu_if ();
    reg_alu_seq dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .prog_len   (prog_len),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .carry_flag (carry_flag),
        .alu        (alu_if)
    );
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    // Record layout: {busy, done, pc[3:0], carry_flag, sel, wr, op, rd_a, rd_b, wr_addr, d_in}
    logic [27:0] exp_q[$];
    logic [20:0] prog [16];
    bit          cout_plan [64];
    int          pc_m = 0;
    bit          carry_m = 1'b0;
    logic [27:0] mon_act, mon_exp;
    function automatic logic [27:0] rec(bit b, bit d, int p, bit c, logic [20:0] w);
        return {b, d, 4'(p), c, w};
    endfunction
    function automatic logic [27:0] observed();
        return {busy, done, pc, carry_flag, alu_if.sel, alu_if.wr, alu_if.op, alu_if.rd_addr_a,
                alu_if.rd_addr_b, alu_if.wr_addr, alu_if.d_in};
    endfunction
    task automatic check(input string name, input logic [27:0] act, input logic [27:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input int a, input logic [20:0] w);
        load_en = 1'b1; load_addr = 4'(a); load_data = w;
        tick();
        load_en = 1'b0;
        prog[a] = w;
    endtask
    task automatic rand_plan();
        for (int c = 0; c < 64; c++) cout_plan[c] = 1'($urandom_range(0, 1));
    endtask
    // Run a program of plen words; optionally poke start/load at cycle poke,
    // abort with reset at cycle abort_c, or load word 0 together with start.
    task automatic run(input int plen, input int poke, input int abort_c, input bit also_load,
                       input logic [20:0] ld);
        int L, n;
        bit cm;
        logic [27:0] tmp[$];
        L = (plen > 16) ? 16 : plen;
        if (also_load) begin
            load_en = 1'b1; load_addr = 4'd0; load_data = ld;
            prog[0] = ld;
        end
        if (L == 0) begin
            tmp.push_back(rec(0, 1, pc_m, carry_m, '0));
        end else begin
            cm = 1'b0;
            for (int i = 0; i < L; i++) begin
                tmp.push_back(rec(1, 0, i, cm, '0));
                tmp.push_back(rec(1, 0, i, cm, prog[i]));
                if (prog[i][20] && prog[i][19]) cm = cout_plan[2*i+2];
            end
            tmp.push_back(rec(0, 1, L - 1, cm, '0));
            pc_m = L - 1;
            carry_m = cm;
        end
        n = (abort_c != 0) ? abort_c : tmp.size();
        for (int k = 0; k < n; k++) exp_q.push_back(tmp[k]);
        prog_len = 5'(plen);
        start = 1'b1;
        tick();
        start = 1'b0; load_en = 1'b0;
        for (int c = 1; c <= n; c++) begin
            alu_if.cout_in = cout_plan[c];
            if (c == poke) begin
                start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = '0;
            end
            if (c == abort_c) reset = 1'b0;
            tick();
            start = 1'b0; load_en = 1'b0; reset = 1'b1;
        end
        alu_if.cout_in = 1'($urandom_range(0, 1));
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending records required=0", exp_q.size());
            exp_q.delete();
        end
        if (abort_c != 0) begin
            pc_m = 0;
            carry_m = 1'b0;
            @(negedge clk);
            check("after_abort", observed(), '0);
            tick();
        end
    endtask
    always @(negedge clk) begin
        mon_act = observed();
        if (busy === 1'b1 || done === 1'b1 || (|mon_act[20:0]) === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_output got=%h required=idle", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL cycle_record got=%h required=%h", mon_act, mon_exp);
                end
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end
    initial begin
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; prog_len = '0; alu_if.cout_in = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("reset_state", observed(), '0);
        reset = 1'b1;
        tick();
        load(0, 21'b0_1_00_000_000_011_11001101);
        load(1, 21'b0_1_00_001_001_101_11100010);
        load(2, 21'b0_1_00_011_101_110_01010101);
        load(3, 21'b0_1_00_010_110_100_10101111);
        rand_plan();
        run(4, 0, 0, 1'b0, '0);
        rand_plan();
        run(4, 3, 0, 1'b0, '0);
        rand_plan();
        run(4, 0, 0, 1'b0, '0);
        rand_plan();
        run(4, 0, 6, 1'b0, '0);
        rand_plan();
        run(4, 0, 0, 1'b0, '0);
        load(0, 21'b1_1_00_000_001_010_00000000);
        load(1, 21'b0_1_00_000_000_011_00010001);
        rand_plan();
        cout_plan[2] = 1'b1;
        cout_plan[4] = 1'b0;
        run(2, 0, 0, 1'b0, '0);
        check("carry_sticky", 28'(carry_flag), 28'(1));
        run(0, 0, 0, 1'b0, '0);
        for (int a = 0; a < 16; a++) load(a, 21'($urandom));
        rand_plan();
        run(31, 0, 0, 1'b0, '0);
        check("pc_final", 28'(pc), 28'(15));
        rand_plan();
        run(3, 0, 0, 1'b1, 21'($urandom));
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) load(a, 21'($urandom));
            rand_plan();
            run($urandom_range(0, 20), 0, 0, 1'b0, '0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
